expr_vector_sweep_ctrl: RTL and testbench

// - Sequencer for one vloghammer expression datapath: 12 operand ports a0..a5/b0..b5, 90-bit result y.
// - On start, generates NUM_VECTORS pseudo-random operand sets from a 60-bit LFSR and drives them to the datapath.
// - Compresses every returned y into a 90-bit MISR signature and reports pass/fail against an expected signature.
// - Sits between the regression harness (start/done) and the datapath under test.

---
 rtl/expr_sweep_pkg.sv | 54 +++++
 rtl/expr_sweep_misr.sv | 44 ++++
 rtl/expr_vector_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_expr_vector_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_sweep_pkg.sv
// ============================================================================
// Module   : expr_sweep_pkg
// Brief    : Shared types and constants for the expression vector sweep
//            controller: FSM states, widths, LFSR/MISR taps and the operand
//            field layout of the vloghammer datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package expr_sweep_pkg;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    // Operand generator width (a-bus plus b-bus) and datapath result width
    localparam int OP_W   = 60;
    localparam int HALF_W = OP_W / 2;
    localparam int Y_W    = 90;

    // Fibonacci LFSR feedback taps: bits 59 and 58
    localparam logic [OP_W-1:0] LFSR_TAPS = {2'b11, 58'd0};
    // All-zero locks the LFSR up, so this replaces a zero seed
    localparam logic [OP_W-1:0] LFSR_INIT = 60'h1;

    // MISR feedback taps: bits 89..86
    localparam logic [Y_W-1:0] MISR_TAPS = {4'b1111, 86'd0};

    // Operand field layout inside op_a / op_b (same packing for a and b)
    localparam int X0_LSB = 0;
    localparam int X0_W   = 4;
    localparam int X1_LSB = 4;
    localparam int X1_W   = 5;
    localparam int X2_LSB = 9;
    localparam int X2_W   = 6;
    localparam int X3_LSB = 15;
    localparam int X3_W   = 4;
    localparam int X4_LSB = 19;
    localparam int X4_W   = 5;
    localparam int X5_LSB = 24;
    localparam int X5_W   = 6;

    // One Fibonacci step of the operand LFSR
    function automatic logic [OP_W-1:0] lfsr_step(input logic [OP_W-1:0] cur);
        return {cur[OP_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/expr_sweep_misr.sv
// ============================================================================
// Module   : expr_sweep_misr
// Brief    : Multiple-input signature register. Shifts left with XOR feedback
//            from the TAPS mask and folds the data word in on every enabled
//            cycle. Clear has priority over enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_sweep_misr
    import expr_sweep_pkg::*;
#(
    parameter int               WIDTH = Y_W,
    parameter logic [WIDTH-1:0] TAPS  = MISR_TAPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_q;
    logic             feedback;

    assign feedback = ^(sig_q & TAPS);

    // Signature register: clear wins, otherwise compress data when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= '0;
        end else if (clear) begin
            sig_q <= '0;
        end else if (enable) begin
            sig_q <= {sig_q[WIDTH-2:0], feedback} ^ data;
        end
    end

    assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/expr_vector_sweep_ctrl.sv
// ============================================================================
// Module   : expr_vector_sweep_ctrl
// Brief    : Sweep sequencer for one expression datapath. Issues NUM_VECTORS
//            LFSR-generated operand sets, tracks them through a DP_LAT-deep
//            valid pipe, compresses the returned results into a MISR and
//            reports pass/fail against the golden signature.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_vector_sweep_ctrl
    import expr_sweep_pkg::*;
#(
    parameter int NUM_VECTORS = 256,
    parameter int DP_LAT      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [OP_W-1:0]   seed,
    input  logic [Y_W-1:0]    expect_sig,
    output logic [HALF_W-1:0] op_a,
    output logic [HALF_W-1:0] op_b,
    input  logic [Y_W-1:0]    dp_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [Y_W-1:0]    signature
);

    // Count value held by the vector being issued when the sweep is complete
    localparam logic [15:0] LAST_COUNT = 16'(NUM_VECTORS - 1);

    sweep_state_t    state;
    sweep_state_t    state_next;
    logic [OP_W-1:0] lfsr;
    logic [15:0]     count;
    logic            issue;
    logic            retire;
    logic            pipe_drained;
    logic            accept_start;
    logic            misr_clear;
    logic            sig_match;
    logic            pass_q;
    logic [Y_W-1:0]  misr;

    // Next-state and per-cycle control; abort overrides everything
    always_comb begin
        state_next   = state;
        issue        = 1'b0;
        accept_start = 1'b0;
        misr_clear   = 1'b0;
        if (abort) begin
            state_next = IDLE;
            misr_clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next   = RUN;
                        accept_start = 1'b1;
                        misr_clear   = 1'b1;
                    end
                end
                RUN: begin
                    issue = 1'b1;
                    if (count == LAST_COUNT) begin
                        // Without datapath registers nothing is left in flight
                        state_next = (DP_LAT == 0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_drained) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, operand LFSR and issue counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lfsr  <= LFSR_INIT;
            count <= '0;
        end else begin
            state <= state_next;
            if (accept_start) begin
                lfsr  <= (seed == '0) ? LFSR_INIT : seed;
                count <= '0;
            end else if (issue) begin
                lfsr  <= lfsr_step(lfsr);
                count <= count + 16'd1;
            end
        end
    end

    // Valid pipe mirroring the datapath register stages
    if (DP_LAT == 0) begin : g_no_pipe
        assign retire       = issue;
        assign pipe_drained = 1'b1;
    end else begin : g_valid_pipe
        logic [DP_LAT-1:0] vpipe;
        logic [DP_LAT-1:0] vpipe_shift;

        assign vpipe_shift  = vpipe << 1;
        assign retire       = vpipe[DP_LAT-1];
        // Empty once the tail retires and nothing else follows it
        assign pipe_drained = (vpipe_shift == '0);

        // Issue flags enter at bit 0 and retire from the top bit
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vpipe <= '0;
            end else if (abort) begin
                vpipe <= '0;
            end else begin
                vpipe <= vpipe_shift | DP_LAT'(issue);
            end
        end
    end

    expr_sweep_misr #(
        .WIDTH (Y_W),
        .TAPS  (MISR_TAPS)
    ) u_misr (
        .clk    (clk),
        .reset  (reset),
        .clear  (misr_clear),
        .enable (retire),
        .data   (dp_y),
        .sig    (misr)
    );

    assign sig_match = (misr == expect_sig);

    // Verdict captured in DONE and held until the next accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_q <= 1'b0;
        end else if (accept_start) begin
            pass_q <= 1'b0;
        end else if (state == DONE) begin
            pass_q <= sig_match;
        end
    end

    assign op_a      = lfsr[OP_W-1:HALF_W];
    assign op_b      = lfsr[HALF_W-1:0];
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign pass      = (state == DONE) ? sig_match : pass_q;
    assign signature = misr;

endmodule

`default_nettype wire

// File: tb/tb_expr_vector_sweep_ctrl.sv
// ============================================================================
// Module   : tb_expr_vector_sweep_ctrl
// Brief    : Bench for expr_vector_sweep_ctrl. Three sequencer instances with
//            different vector counts and datapath latencies, each driving a
//            delay-line datapath stub; results are compared against a
//            behavioural signature model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_expr_vector_sweep_ctrl;
    import expr_sweep_pkg::*;

    localparam int NI = 3;
    localparam int NV     [NI] = '{3, 3, 20};
    localparam int LAT_OF [NI] = '{0, 2, 3};

    logic        clk;
    logic        reset;
    logic        start      [NI];
    logic        abort      [NI];
    logic [59:0] seed       [NI];
    logic [89:0] expect_sig [NI];
    logic [29:0] op_a       [NI];
    logic [29:0] op_b       [NI];
    logic [89:0] dp_y       [NI];
    logic        busy       [NI];
    logic        done       [NI];
    logic        pass       [NI];
    logic [89:0] signature  [NI];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    expr_vector_sweep_ctrl #(.NUM_VECTORS(3), .DP_LAT(0)) dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .seed(seed[0]), .expect_sig(expect_sig[0]), .op_a(op_a[0]), .op_b(op_b[0]),
        .dp_y(dp_y[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .signature(signature[0]));

    expr_vector_sweep_ctrl #(.NUM_VECTORS(3), .DP_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .seed(seed[1]), .expect_sig(expect_sig[1]), .op_a(op_a[1]), .op_b(op_b[1]),
        .dp_y(dp_y[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .signature(signature[1]));

    expr_vector_sweep_ctrl #(.NUM_VECTORS(20), .DP_LAT(3)) dut_c (
        .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]),
        .seed(seed[2]), .expect_sig(expect_sig[2]), .op_a(op_a[2]), .op_b(op_b[2]),
        .dp_y(dp_y[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .signature(signature[2]));

    // Datapath stubs: y = {30'd0, op_a, op_b} delayed by the instance latency
    for (genvar k = 0; k < NI; k++) begin : g_stub
        localparam int L = LAT_OF[k];
        logic [89:0] dly [8];

        // Delay line standing in for the datapath register stages
        always @(posedge clk) begin
            dly[0] <= {30'd0, op_a[k], op_b[k]};
            for (int i = 1; i < 8; i++) dly[i] <= dly[i-1];
        end

        if (L == 0) begin : g_comb
            assign dp_y[k] = {30'd0, op_a[k], op_b[k]};
        end else begin : g_reg
            assign dp_y[k] = dly[L-1];
        end
    end

    // Operand set number i (0-based) of a sweep started with seed s
    function automatic logic [59:0] model_op(input logic [59:0] s, input int i);
        logic [59:0] v;
        v = (s == 60'd0) ? 60'd1 : s;
        for (int j = 0; j < i; j++) v = {v[58:0], v[59] ^ v[58]};
        return v;
    endfunction

    // Signature of a full sweep of n vectors through the stub datapath
    function automatic logic [89:0] model_sig(input logic [59:0] s, input int n);
        logic [89:0] m;
        m = '0;
        for (int i = 0; i < n; i++)
            m = {m[88:0], m[89] ^ m[88] ^ m[87] ^ m[86]} ^ {30'd0, model_op(s, i)};
        return m;
    endfunction

    task automatic chk(input string tag, input logic [89:0] obs, input logic [89:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full sweep on instance k; optionally pulses start during RUN/DRAIN
    task automatic run_sweep(input int k, input logic [59:0] s, input bit want_pass,
                             input bit poke);
        logic [89:0] golden;
        int t;
        golden        = model_sig(s, NV[k]);
        seed[k]       = s;
        expect_sig[k] = want_pass ? golden : golden ^ 90'h1;
        start[k]      = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        t = 1;
        while (done[k] !== 1'b1 && t < 300) begin
            chk($sformatf("busy[%0d] t=%0d", k, t), 90'(busy[k]), 90'd1);
            if (t <= NV[k])
                chk($sformatf("operands[%0d] t=%0d", k, t),
                    {30'd0, op_a[k], op_b[k]}, {30'd0, model_op(s, t - 1)});
            start[k] = poke && (t == 2 || t == NV[k] + 1);
            @(negedge clk);
            t++;
        end
        start[k] = 1'b0;
        chk($sformatf("done_cycle[%0d]", k), 90'(t), 90'(1 + NV[k] + LAT_OF[k]));
        chk($sformatf("signature[%0d]", k), signature[k], golden);
        chk($sformatf("pass[%0d]", k), 90'(pass[k]), 90'(want_pass));
        chk($sformatf("busy_in_done[%0d]", k), 90'(busy[k]), 90'd0);
        expect_sig[k] = want_pass ? golden ^ 90'h1 : golden;
        #1;
        chk($sformatf("pass_flip[%0d]", k), 90'(pass[k]), 90'(!want_pass));
        expect_sig[k] = want_pass ? golden : golden ^ 90'h1;
        @(negedge clk);
        chk($sformatf("done_pulse_end[%0d]", k), 90'(done[k]), 90'd0);
        chk($sformatf("idle_busy[%0d]", k), 90'(busy[k]), 90'd0);
        chk($sformatf("sig_held[%0d]", k), signature[k], golden);
        chk($sformatf("pass_held[%0d]", k), 90'(pass[k]), 90'(want_pass));
    endtask

    initial begin
        logic [63:0] r64;
        logic [59:0] rs;
        bit          saw_done;

        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0; abort[k] = 1'b0; seed[k] = '0; expect_sig[k] = '0;
        end
        repeat (2) @(negedge clk);

        // Reset state of every instance
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_busy[%0d]", k), 90'(busy[k]), 90'd0);
            chk($sformatf("rst_done[%0d]", k), 90'(done[k]), 90'd0);
            chk($sformatf("rst_pass[%0d]", k), 90'(pass[k]), 90'd0);
            chk($sformatf("rst_sig[%0d]", k), signature[k], 90'd0);
            chk($sformatf("rst_ops[%0d]", k), {30'd0, op_a[k], op_b[k]}, 90'd1);
        end
        reset = 1'b0;
        @(negedge clk);

        // Three vectors, no datapath latency, seed 1
        run_sweep(0, 60'h1, 1'b1, 1'b0);
        chk("t2_sig_literal", signature[0], 90'h4);

        // Same sweep through two datapath stages
        run_sweep(1, 60'h1, 1'b1, 1'b0);
        chk("t3_sig_literal", signature[1], 90'h4);

        // Abort in IDLE clears the held signature
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        chk("idle_abort_sig", signature[1], 90'd0);
        chk("idle_abort_busy", 90'(busy[1]), 90'd0);

        // Zero seed behaves like seed 1
        run_sweep(0, 60'h0, 1'b0, 1'b0);
        chk("t4_sig_literal", signature[0], 90'h4);

        // Abort on the second RUN cycle with start held high
        seed[0] = 60'h1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        chk("t5_sig_before_abort", signature[0], 90'h1);
        abort[0] = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        start[0] = 1'b0;
        chk("t5_busy", 90'(busy[0]), 90'd0);
        chk("t5_done", 90'(done[0]), 90'd0);
        chk("t5_sig", signature[0], 90'd0);
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done[0] === 1'b1 || busy[0] === 1'b1) saw_done = 1'b1;
        end
        chk("t5_quiet", 90'(saw_done), 90'd0);

        // Abort and start together in IDLE: abort wins
        abort[0] = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        start[0] = 1'b0;
        chk("abort_over_start", 90'(busy[0]), 90'd0);
        run_sweep(0, 60'h1, 1'b1, 1'b0);

        // Start pulses during RUN and DRAIN are ignored
        run_sweep(1, 60'h1, 1'b1, 1'b1);
        run_sweep(2, 60'h0F0F_0000_1234_567, 1'b1, 1'b1);

        // Randomised seeds on the longer, deeper instance
        for (int r = 0; r < 5; r++) begin
            r64 = {$urandom, $urandom};
            rs  = r64[59:0];
            run_sweep(2, rs, 1'($urandom_range(0, 1)), 1'b0);
        end
        r64 = {$urandom, $urandom};
        rs  = r64[59:0];
        run_sweep(1, rs, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a sweep
        seed[2] = 60'hFFF_FFFF_FFFF_FFFF;
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("t1_busy_before", 90'(busy[2]), 90'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_busy", 90'(busy[2]), 90'd0);
        chk("t1_done", 90'(done[2]), 90'd0);
        chk("t1_sig", signature[2], 90'd0);
        chk("t1_op_a", 90'(op_a[2]), 90'd0);
        chk("t1_op_b", 90'(op_b[2]), 90'd1);
        chk("t1_b0_field", 90'(op_b[2][X0_LSB +: X0_W]), 90'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t1_stays_idle", 90'(busy[2]), 90'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
